// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store controller.
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    DROP_REQ  = 3'd3,
    DROP_WAIT = 3'd4
  } lsu_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align : alignment check, store strobe/data generation, load extension
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  mem_op_t           i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr,
  output logic [1:0]        o_size,
  output logic [3:0]        o_wstrb,
  output logic [31:0]       o_wdata,
  input  mem_op_t           i_ld_op,
  input  logic [1:0]        i_ld_off,
  input  logic [31:0]       i_rdata,
  output logic [31:0]       o_ld_data
);

  logic       w_bad;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_size = SIZE_W;
    case (i_op)
      LB, LBU, SB: o_size = SIZE_B;
      LH, LHU, SH: o_size = SIZE_H;
      default:     o_size = SIZE_W;
    endcase

    w_bad = ((o_size == SIZE_H) && i_addr[0]) ||
            ((o_size == SIZE_W) && (i_addr[1:0] != 2'b00));
    o_misalign = (ALIGN_CHECK != 0) ? w_bad : 1'b0;

    // Without checking, misaligned low bits are silently dropped.
    o_addr = i_addr;
    if (ALIGN_CHECK == 0) begin
      if (o_size == SIZE_H) o_addr[0] = 1'b0;
      if (o_size == SIZE_W) o_addr[1:0] = 2'b00;
    end

    o_wr = is_store(i_op);

    case (o_size)
      SIZE_B:  begin
        o_wstrb = 4'b0001 << o_addr[1:0];
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_H:  begin
        o_wstrb = 4'b0011 << {o_addr[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
    if (!o_wr) o_wstrb = 4'b0000;
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_ld_op)
      LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ld_data = {24'd0, w_byte};
      LH:      o_ld_data = {{16{w_half[15]}}, w_half};
      LHU:     o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl : M-stage load/store controller with SRAM-like bus handshake
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ALIGN_CHECK = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              laddrerr,
  output logic              saddrerr,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_t        r_state, w_next;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_err;

  logic              w_mis, w_al_wr;
  logic [ADDR_W-1:0] w_al_addr;
  logic [1:0]        w_al_size;
  logic [3:0]        w_al_wstrb;
  logic [31:0]       w_al_wdata, w_ld_data;
  logic              w_go, w_accept, w_err, w_to, w_bus_err_set;

  lsu_align #(
    .ADDR_W      (ADDR_W),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_align (
    .i_op       (mem_op_t'(mem_op)),
    .i_addr     (mem_addr),
    .i_wdata    (mem_wdata),
    .o_misalign (w_mis),
    .o_addr     (w_al_addr),
    .o_wr       (w_al_wr),
    .o_size     (w_al_size),
    .o_wstrb    (w_al_wstrb),
    .o_wdata    (w_al_wdata),
    .i_ld_op    (r_op),
    .i_ld_off   (r_addr[1:0]),
    .i_rdata    (data_rdata),
    .o_ld_data  (w_ld_data)
  );

  assign w_go     = (r_state == IDLE) && mem_valid && !flush;
  assign w_accept = w_go && !w_mis;
  assign w_err    = w_go && w_mis;
  assign w_to     = (TIMEOUT_CYC != 0) && (r_cnt == c_TO_LAST);

  always_comb begin
    w_next        = r_state;
    stall         = 1'b0;
    load_valid    = 1'b0;
    w_bus_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        // The request goes out in the accept cycle, so addr_ok can skip REQ.
        if (w_accept) begin
          stall  = 1'b1;
          w_next = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (data_addr_ok)  w_next = flush ? DROP_WAIT : WAIT;
        else if (flush)    w_next = DROP_REQ;
      end
      WAIT: begin
        if (data_data_ok) begin
          w_next     = IDLE;
          load_valid = !r_wr && !flush;
        end else if (flush) begin
          stall  = 1'b1;
          w_next = DROP_WAIT;
        end else if (w_to) begin
          stall         = 1'b1;
          w_next        = IDLE;
          w_bus_err_set = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      DROP_REQ: begin
        stall = 1'b1;
        if (data_addr_ok) w_next = DROP_WAIT;
      end
      DROP_WAIT: begin
        stall = 1'b1;
        if (data_data_ok) begin
          w_next = IDLE;
        end else if (w_to) begin
          w_next        = IDLE;
          w_bus_err_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_op      <= LB;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_wstrb   <= 4'd0;
      r_wdata   <= 32'd0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_bus_err_set;
      if (w_accept) begin
        r_op    <= mem_op_t'(mem_op);
        r_addr  <= w_al_addr;
        r_wr    <= w_al_wr;
        r_size  <= w_al_size;
        r_wstrb <= w_al_wstrb;
        r_wdata <= w_al_wdata;
      end
      if ((w_next == WAIT || w_next == DROP_WAIT) && (w_next != r_state))
        r_cnt <= '0;
      else if ((TIMEOUT_CYC != 0) && (r_state == WAIT || r_state == DROP_WAIT))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign data_req   = w_accept || (r_state == REQ) || (r_state == DROP_REQ);
  assign data_wr    = w_accept ? w_al_wr    : r_wr;
  assign data_size  = w_accept ? w_al_size  : r_size;
  assign data_addr  = w_accept ? w_al_addr  : r_addr;
  assign data_wdata = w_accept ? w_al_wdata : r_wdata;
  assign data_wstrb = w_accept ? w_al_wstrb : r_wstrb;

  assign laddrerr  = w_err && !w_al_wr;
  assign saddrerr  = w_err && w_al_wr;
  assign badvaddr  = w_err ? mem_addr : '0;
  assign load_data = load_valid ? w_ld_data : 32'd0;
  assign bus_err   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: load results checked through a scoreboard queue.
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_mem_ctrl;

  localparam logic [2:0] c_LB = 3'd0, c_LBU = 3'd1, c_LH = 3'd2, c_LHU = 3'd3,
                         c_LW = 3'd4, c_SB = 3'd5, c_SH = 3'd6, c_SW = 3'd7;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, valid_b, flush;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic        data_req, data_wr, stall, load_valid, laddrerr, saddrerr, bus_err;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, load_data, badvaddr;
  logic [3:0]  data_wstrb;

  logic        b_req, b_wr, b_stall, b_lv, b_lerr, b_serr, b_berr;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_ldata, b_bad;
  logic [3:0]  b_wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];
  int stalls, errs;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32), .ALIGN_CHECK(1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .laddrerr(laddrerr), .saddrerr(saddrerr), .badvaddr(badvaddr), .bus_err(bus_err)
  );

  lsu_mem_ctrl #(.ADDR_W(32), .ALIGN_CHECK(0), .TIMEOUT_CYC(0)) dut_noalign (
    .clk(clk), .resetn(resetn), .mem_valid(valid_b), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
    .data_req(b_req), .data_wr(b_wr), .data_size(b_size),
    .data_addr(b_addr), .data_wdata(b_wdata), .data_wstrb(b_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .stall(b_stall), .load_valid(b_lv), .load_data(b_ldata),
    .laddrerr(b_lerr), .saddrerr(b_serr), .badvaddr(b_bad), .bus_err(b_berr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic clr;
    mem_valid = 0; valid_b = 0; flush = 0;
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  // Load with immediate addr_ok and data_ok 'gap' cycles later; returns stalled cycles.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp,
                         input int gap, output int n_stall);
    n_stall = 0;
    mem_valid = 1; mem_op = op; mem_addr = addr; data_addr_ok = 1;
    sb.push_back(exp);
    smp; n_stall += int'(stall);
    chk("ld_req", {31'd0, data_req}, 32'd1);
    cyc;
    mem_valid = 0; data_addr_ok = 0;
    for (int i = 1; i < gap; i++) begin
      smp; n_stall += int'(stall); cyc;
    end
    data_data_ok = 1; data_rdata = rd;
    smp; n_stall += int'(stall); cyc;
    data_data_ok = 0;
  endtask

  // Scoreboard: every load_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (resetn === 1'b1 && load_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_load_valid", 32'd1, 32'd0);
      else chk("load_data", load_data, sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 0; clr();
    mem_op = 0; mem_addr = 0; mem_wdata = 0; data_rdata = 0;
    cyc; cyc;
    smp;
    chk("rst_req",   {31'd0, data_req},  32'd0);
    chk("rst_stall", {31'd0, stall},     32'd0);
    chk("rst_berr",  {31'd0, bus_err},   32'd0);
    chk("rst_addr",  data_addr,          32'd0);
    chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
    cyc;
    resetn = 1;
    cyc;

    // LW, stall high for exactly three cycles
    do_load(c_LW, 32'h1000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, stalls);
    chk("lw_stall_cycles", stalls, 32'd3);
    smp;
    chk("lw_after_stall", {31'd0, stall}, 32'd0);
    cyc;

    // Byte / half loads with sign and zero extension, best-case latency
    do_load(c_LB,  32'h1000_0003, 32'h8000_0000, 32'hFFFF_FF80, 1, stalls);
    chk("best_case_stall", stalls, 32'd1);
    do_load(c_LBU, 32'h1000_0003, 32'h8000_0000, 32'h0000_0080, 1, stalls);
    do_load(c_LH,  32'h1000_0002, 32'h8001_1234, 32'hFFFF_8001, 2, stalls);
    do_load(c_LHU, 32'h1000_0000, 32'h8001_F234, 32'h0000_F234, 1, stalls);

    // SH with delayed addr_ok: bus outputs held in REQ
    mem_valid = 1; mem_op = c_SH; mem_addr = 32'h1000_0002; mem_wdata = 32'h1234_ABCD;
    smp;
    chk("sh_wr",    {31'd0, data_wr},     32'd1);
    chk("sh_size",  {30'd0, data_size},   32'd1);
    chk("sh_wstrb", {28'd0, data_wstrb},  32'hC);
    chk("sh_wdata", data_wdata,           32'hABCD_ABCD);
    cyc;
    mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_op = c_LB; data_addr_ok = 1;
    smp;
    chk("sh_hold_req",   {31'd0, data_req},    32'd1);
    chk("sh_hold_wstrb", {28'd0, data_wstrb},  32'hC);
    chk("sh_hold_wdata", data_wdata,           32'hABCD_ABCD);
    chk("sh_hold_addr",  data_addr,            32'h1000_0002);
    cyc;
    data_addr_ok = 0; data_data_ok = 1;
    smp;
    chk("sh_done_stall", {31'd0, stall},      32'd0);
    chk("sh_no_lv",      {31'd0, load_valid}, 32'd0);
    cyc; clr();

    // SB lane replication
    mem_valid = 1; mem_op = c_SB; mem_addr = 32'h1000_0001; mem_wdata = 32'h0000_0077;
    data_addr_ok = 1;
    smp;
    chk("sb_wstrb", {28'd0, data_wstrb}, 32'h2);
    chk("sb_wdata", data_wdata,          32'h7777_7777);
    chk("sb_size",  {30'd0, data_size},  32'd0);
    cyc;
    mem_valid = 0; data_addr_ok = 0; data_data_ok = 1;
    smp; cyc; clr();

    // Misaligned accesses
    mem_valid = 1; mem_op = c_LW; mem_addr = 32'h1000_0006;
    smp;
    chk("adel_flag",  {31'd0, laddrerr}, 32'd1);
    chk("adel_bad",   badvaddr,          32'h1000_0006);
    chk("adel_noreq", {31'd0, data_req}, 32'd0);
    chk("adel_stall", {31'd0, stall},    32'd0);
    cyc;
    mem_op = c_SW; mem_addr = 32'h1000_0001;
    smp;
    chk("ades_flag", {31'd0, saddrerr}, 32'd1);
    chk("ades_lerr", {31'd0, laddrerr}, 32'd0);
    cyc;

    // No alignment check: LW 0x..06 issues to 0x..04
    mem_valid = 0; valid_b = 1; mem_op = c_LW; mem_addr = 32'h1000_0006;
    smp;
    chk("na_req",   {31'd0, b_req},  32'd1);
    chk("na_addr",  b_addr,          32'h1000_0004);
    chk("na_noerr", {31'd0, b_lerr}, 32'd0);
    chk("a_idle",   {31'd0, data_req}, 32'd0);
    cyc;
    valid_b = 0; data_addr_ok = 1;
    smp; cyc;
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    smp;
    chk("na_lv",    {31'd0, b_lv}, 32'd1);
    chk("na_ldata", b_ldata,       32'hCAFE_F00D);
    cyc; clr();

    // Flush in REQ before addr_ok: request held, response dropped
    mem_valid = 1; mem_op = c_LW; mem_addr = 32'h1000_0010;
    smp; cyc;
    mem_valid = 0; flush = 1;
    smp;
    chk("fl_req_held", {31'd0, data_req}, 32'd1);
    cyc;
    flush = 0;
    smp;
    chk("fl_drop_req", {31'd0, data_req}, 32'd1);
    chk("fl_drop_addr", data_addr,        32'h1000_0010);
    cyc;
    data_addr_ok = 1;
    smp;
    chk("fl_req_last", {31'd0, data_req}, 32'd1);
    cyc;
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1111_1111;
    smp;
    chk("fl_no_lv", {31'd0, load_valid}, 32'd0);
    cyc; clr();
    smp;
    chk("fl_stall_rel", {31'd0, stall},    32'd0);
    chk("fl_req_rel",   {31'd0, data_req}, 32'd0);
    cyc;

    // Flush and data_ok together in WAIT: completion, no load_valid
    mem_valid = 1; mem_op = c_LW; mem_addr = 32'h1000_0008; data_addr_ok = 1;
    smp; cyc;
    mem_valid = 0; data_addr_ok = 0; data_data_ok = 1; flush = 1; data_rdata = 32'h5555_5555;
    smp;
    chk("fw_no_lv", {31'd0, load_valid}, 32'd0);
    chk("fw_stall", {31'd0, stall},      32'd0);
    cyc; clr();

    // Watchdog: no data_ok after WAIT entry
    mem_valid = 1; mem_op = c_LW; mem_addr = 32'h1000_0020; data_addr_ok = 1;
    smp; cyc;
    mem_valid = 0; data_addr_ok = 0;
    errs = 0;
    for (int i = 1; i <= 8; i++) begin
      smp; errs += int'(bus_err); cyc;
    end
    chk("to_early", errs, 32'd0);
    smp;
    chk("to_pulse", {31'd0, bus_err}, 32'd1);
    chk("to_stall", {31'd0, stall},   32'd0);
    cyc;
    data_data_ok = 1; data_rdata = 32'h9999_9999;
    smp;
    chk("to_pulse_end", {31'd0, bus_err},    32'd0);
    chk("to_stray_lv",  {31'd0, load_valid}, 32'd0);
    cyc; clr();
    smp; cyc;

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Memory-stage load/store controller for the MIPS core. It checks address alignment and raises the address-error exceptions, then generates byte strobes and replicated store data. It runs the request/response handshake to the SRAM-like data bus, stalling the pipeline until the access completes, and sign- or zero-extends load data. It sits between the M-stage pipeline register and the data-side bus or cache. It handles flushes that arrive mid-transaction and has an optional bus-timeout watchdog.

## Interface
Parameters:
- ADDR_W, 32, address width; must be ≥ 2.
- ALIGN_CHECK, 1. When 1, misaligned accesses raise exceptions. When 0, addr[1:0] or addr[0] are forced to zero and the access is issued.
- TIMEOUT_CYC, 0. Cycles in WAIT before bus_err is raised; 0 disables the watchdog. Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  M-stage holds a memory instruction.
- mem_op  in  3  access type, encoded per mem_op_t.
- mem_addr  in  ADDR_W  effective address.
- mem_wdata  in  32  store source register.
- flush  in  1  exception or eret flush of M stage.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  32  lane-replicated store data.
- data_wstrb  out  4  byte enables; 0 for loads.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or store acknowledgement.
- data_rdata  in  32  load data.
- stall  out  1  freeze the pipeline.
- load_valid  out  1  load_data is valid this cycle.
- load_data  out  32  extended load result.
- laddrerr  out  1  load address error (AdEL).
- saddrerr  out  1  store address error (AdES).
- badvaddr  out  ADDR_W  faulting address.
- bus_err  out  1  watchdog expired.

## Operation
- Alignment error (ALIGN_CHECK = 1):
  - LH/LHU/SH with addr[0] ≠ 0 is an error.
  - LW/SW with addr[1:0] ≠ 0 is an error.
  - The error is combinational in IDLE when mem_valid = 1 and flush = 0. laddrerr or saddrerr is set and badvaddr = mem_addr.
  - No request is issued and stall = 0.
  - Every output is driven in every branch; no latches are inferred.
- Strobes:
  - SB: 4'b0001 << a[1:0].
  - SH: 4'b0011 << {a[1],1'b0}.
  - SW: 4'b1111.
- Store data: SB uses {4{wdata[7:0]}}, SH uses {2{wdata[15:0]}}, SW uses wdata unchanged.
- Load extraction:
  - The byte or half is selected from data_rdata by the latched addr[1:0].
  - LB and LH are sign-extended; LBU and LHU are zero-extended.
- FSM states: IDLE, REQ, WAIT, DROP_REQ, DROP_WAIT.
  - IDLE → REQ on mem_valid ∧ ¬err ∧ ¬flush. Op, address, strobes and data are latched at this point.
  - REQ: data_req = 1, and all bus outputs are held stable until data_addr_ok. On data_addr_ok go to WAIT. If flush arrives first, go to DROP_REQ; req is still held.
  - WAIT: on data_data_ok go to IDLE. For a load, load_valid = 1 that cycle. If flush arrives, go to DROP_WAIT.
  - DROP_REQ: keep data_req until data_addr_ok, then go to DROP_WAIT.
  - DROP_WAIT: on data_data_ok go to IDLE; the response is discarded and load_valid stays 0.
- Stall rules:
  - stall = 1 in REQ, WAIT and both DROP states.
  - stall = 1 in IDLE when a valid, non-erroring access is being accepted.
  - stall = 0 in the WAIT cycle where data_data_ok is seen.
- Watchdog:
  - The counter clears on entry to WAIT or DROP_WAIT and increments each cycle there.
  - When it reaches TIMEOUT_CYC, bus_err pulses for one cycle and the FSM goes to IDLE.
  - A late data_data_ok received in IDLE is ignored.
- Reset values: state = IDLE; data_req, data_wr, stall, load_valid, laddrerr, saddrerr and bus_err are 0; data_addr, data_wdata, data_wstrb, badvaddr and load_data are 0; counter = 0.

## Timing
- Best case: request in cycle 0 with addr_ok in cycle 0, data_ok in cycle 1, so load_valid and the stall release occur in cycle 1. Total latency is 2 cycles.
- data_addr_ok and data_data_ok in the same cycle are legal only when the FSM is in WAIT. An addr_ok in REQ moves to WAIT; the next data_ok is consumed.
- flush and data_data_ok in the same WAIT cycle: completion wins and load_valid = 0. The flushed instruction does not retire.
- Reset deassertion mid-transaction: the FSM restarts in IDLE. The bus owner is reset by the same resetn.

## Structure
- Shared package lsu_pkg holds:
  - mem_op_t: LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7.
  - lsu_state_t.
  - SIZE_B/H/W constants.
- Sub-module lsu_align: combinational error check, strobe and store-data generation, and load extraction/extension. It is reused by the FSM top.

## Test plan
- LW at 0x1000_0004, addr_ok immediate, data_ok 3 cycles later with rdata 0xDEAD_BEEF: load_data = 0xDEAD_BEEF, and stall is high for exactly 3 cycles.
- LB at 0x...03 with rdata 0x80_00_00_00: load_data = 0xFFFF_FF80. The same access as LBU: load_data = 0x0000_0080.
- SH at 0x...02 with wdata 0x1234_ABCD: wstrb = 4'b1100, data_wdata = 0xABCD_ABCD, data_size = 1.
- LW at 0x...06: laddrerr = 1, badvaddr = 0x...06, data_req never rises. SW at 0x...01: saddrerr = 1. With ALIGN_CHECK = 0, the LW at 0x...06 issues data_addr = 0x...04 and no error is raised.
- flush raised in REQ before addr_ok: data_req is held until addr_ok, the FSM enters DROP_WAIT, the response is discarded, load_valid stays 0, and stall drops after data_ok.
- TIMEOUT_CYC = 8 with no data_ok: bus_err pulses 8 cycles after WAIT entry, the FSM returns to IDLE, and a later stray data_ok causes no load_valid.
